mem_bus_interconnect: RTL and testbench

MEM_BUS_INTERCONNECT -- requirements
Module: mem_bus_interconnect

---
 rtl/mem_bus_pkg.sv | 27 ++
 rtl/mem_bus_decoder.sv | 28 ++
 rtl/mem_bus_interconnect.sv | 147 ++++++++++++++
 tb/tb_mem_bus_interconnect.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared FSM states, error codes and default decode map
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int          DEF_NUM_SLAVES     = 4;
  localparam int          DEF_TIMEOUT_CYCLES = 1024;
  localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEAD_BEEF;

  localparam logic [4*32-1:0] DEF_SLAVE_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [4*32-1:0] DEF_SLAVE_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_C000, 32'hFFFF_C000};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - priority address decoder, lowest matching slave wins
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int                       IDX_W      = 2
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest matching index overwrites the rest.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLAVE_MASK[i*32 +: 32]) ==
          (SLAVE_BASE[i*32 +: 32] & SLAVE_MASK[i*32 +: 32])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_interconnect.sv
// rtl/mem_bus_interconnect.sv - one master to NUM_SLAVES memory bus router
// with decode-miss and slave-timeout error responses.
module mem_bus_interconnect
  import mem_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = DEF_SLAVE_MASK,
  parameter int                       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0]              ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_valid,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic                       err_pulse,
  output logic [1:0]                 err_code,
  output logic [31:0]                err_addr,
  output logic [7:0]                 err_count,
  output logic                       busy
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e           r_state;
  state_e           w_next;
  logic [IDX_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_sel_ready;
  logic [31:0]      w_sel_rdata;
  logic             w_timeout;

  mem_bus_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .i_addr (m_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == IDX_W'(i)) begin
        w_sel_ready = s_ready[i];
        w_sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  // A ready in the last allowed cycle wins over the timeout.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && !w_sel_ready &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    s_valid   = '0;
    m_ready   = 1'b0;
    m_rdata   = '0;
    err_pulse = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (m_valid) w_next = w_hit ? ST_ACCESS : ST_ERROR;
      end
      ST_ACCESS: begin
        for (int i = 0; i < NUM_SLAVES; i++) s_valid[i] = (r_sel == IDX_W'(i));
        m_ready = w_sel_ready;
        m_rdata = w_sel_ready ? w_sel_rdata : 32'd0;
        if (w_sel_ready || !m_valid) w_next = ST_IDLE;
        else if (w_timeout)          w_next = ST_ERROR;
      end
      ST_ERROR: begin
        m_ready   = 1'b1;
        m_rdata   = ERR_RDATA;
        err_pulse = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Error status is logged on entry to ERROR so it is visible with the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_cnt     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      err_code  <= ERR_NONE;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m_valid && w_hit) begin
            r_sel   <= w_idx;
            r_cnt   <= '0;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
          end else if (m_valid) begin
            err_addr  <= m_addr;
            err_code  <= ERR_DECODE;
            err_count <= sat_inc8(err_count);
          end
        end
        ST_ACCESS: begin
          if (m_valid && !w_sel_ready) begin
            if (w_timeout) begin
              err_addr  <= s_addr;
              err_code  <= ERR_TIMEOUT;
              err_count <= sat_inc8(err_count);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// tb/tb_mem_bus_interconnect.sv - directed self-checking bench for mem_bus_interconnect
module tb_mem_bus_interconnect;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_valid;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_pulse;
  logic [1:0]   err_code;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  always #5 clk = ~clk;

  mem_bus_interconnect #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_pulse(err_pulse), .err_code(err_code), .err_addr(err_addr),
    .err_count(err_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_valid = 1'b1;
    m_addr  = a;
    m_wdata = d;
    m_wstrb = s;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_svalid"}, 32'(s_valid), 32'h0);
    chk({tag, "_mready"}, 32'(m_ready), 32'h0);
    chk({tag, "_mrdata"}, m_rdata, 32'h0);
    chk({tag, "_saddr"}, s_addr, 32'h0);
    chk({tag, "_swdata"}, s_wdata, 32'h0);
    chk({tag, "_swstrb"}, 32'(s_wstrb), 32'h0);
    chk({tag, "_epulse"}, 32'(err_pulse), 32'h0);
    chk({tag, "_ecode"}, 32'(err_code), 32'h0);
    chk({tag, "_eaddr"}, err_addr, 32'h0);
    chk({tag, "_ecount"}, 32'(err_count), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; s_rdata = '0;
    step(); step(); #1;
    check_reset_values("rst");
    step(); rst_n = 1'b1;

    // Read to slave 1, ready on the third ACCESS cycle; others' ready ignored.
    step(); request(32'h0001_0010, 32'h0, 4'h0); s_ready = 4'b1101; #1;
    chk("rd_idle_mready", 32'(m_ready), 32'h0);
    for (int k = 1; k <= 2; k++) begin
      step(); s_ready = 4'b1101; #1;
      chk($sformatf("rd_wait%0d_svalid", k), 32'(s_valid), 32'h2);
      chk($sformatf("rd_wait%0d_mready", k), 32'(m_ready), 32'h0);
      chk($sformatf("rd_wait%0d_mrdata", k), m_rdata, 32'h0);
    end
    step(); s_ready = 4'b0010; s_rdata[32 +: 32] = 32'h1234_5678; s_rdata[0 +: 32] = 32'h1111_1111; #1;
    chk("rd_svalid", 32'(s_valid), 32'h2);
    chk("rd_mready", 32'(m_ready), 32'h1);
    chk("rd_mrdata", m_rdata, 32'h1234_5678);
    chk("rd_ecount", 32'(err_count), 32'h0);
    step(); m_valid = 1'b0; s_ready = '0; #1;
    chk("rd_done_busy", 32'(busy), 32'h0);
    chk("rd_done_svalid", 32'(s_valid), 32'h0);

    // Write to slave 2 ready immediately, then a back-to-back read to slave 0.
    step(); request(32'h1000_0004, 32'hA5A5_A5A5, 4'b0011); s_ready = 4'b0100; #1;
    chk("wr_idle_mready", 32'(m_ready), 32'h0);
    step(); #1;
    chk("wr_svalid", 32'(s_valid), 32'h4);
    chk("wr_saddr", s_addr, 32'h1000_0004);
    chk("wr_swdata", s_wdata, 32'hA5A5_A5A5);
    chk("wr_swstrb", 32'(s_wstrb), 32'h3);
    chk("wr_mready", 32'(m_ready), 32'h1);
    step(); request(32'h0000_0100, 32'h0, 4'h0); s_ready = '0; #1;
    chk("b2b_idle_busy", 32'(busy), 32'h0);
    step(); s_ready = 4'b0001; s_rdata[0 +: 32] = 32'hCAFE_0001; #1;
    chk("b2b_svalid", 32'(s_valid), 32'h1);
    chk("b2b_mready", 32'(m_ready), 32'h1);
    chk("b2b_mrdata", m_rdata, 32'hCAFE_0001);
    step(); m_valid = 1'b0; s_ready = '0;

    // Decode miss.
    step(); request(32'h3000_0000, 32'h5555_5555, 4'hF); #1;
    chk("miss_idle_svalid", 32'(s_valid), 32'h0);
    step(); m_valid = 1'b0; #1;
    chk("miss_svalid", 32'(s_valid), 32'h0);
    chk("miss_mready", 32'(m_ready), 32'h1);
    chk("miss_mrdata", m_rdata, 32'hDEAD_BEEF);
    chk("miss_epulse", 32'(err_pulse), 32'h1);
    chk("miss_ecode", 32'(err_code), 32'h1);
    chk("miss_eaddr", err_addr, 32'h3000_0000);
    chk("miss_ecount", 32'(err_count), 32'h1);
    step(); #1;
    chk("miss_after_busy", 32'(busy), 32'h0);
    chk("miss_after_epulse", 32'(err_pulse), 32'h0);
    chk("miss_after_mready", 32'(m_ready), 32'h0);

    // Slave 3 never ready: 16 ACCESS cycles, then a timeout error.
    step(); request(32'h2000_0008, 32'h0, 4'h0); #1;
    for (int k = 1; k <= 16; k++) begin
      step(); #1;
      chk($sformatf("to_c%0d_svalid", k), 32'(s_valid), 32'h8);
    end
    step(); m_valid = 1'b0; #1;
    chk("to_svalid", 32'(s_valid), 32'h0);
    chk("to_mready", 32'(m_ready), 32'h1);
    chk("to_mrdata", m_rdata, 32'hDEAD_BEEF);
    chk("to_ecode", 32'(err_code), 32'h2);
    chk("to_eaddr", err_addr, 32'h2000_0008);
    chk("to_ecount", 32'(err_count), 32'h2);
    chk("to_epulse", 32'(err_pulse), 32'h1);

    // Slave 3 ready on the 16th cycle: normal completion.
    step(); request(32'h2000_0004, 32'h0, 4'h0); #1;
    for (int k = 1; k <= 15; k++) begin
      step(); #1;
      chk($sformatf("tr_c%0d_mready", k), 32'(m_ready), 32'h0);
    end
    step(); s_ready = 4'b1000; s_rdata[96 +: 32] = 32'h0BAD_F00D; #1;
    chk("tr_svalid", 32'(s_valid), 32'h8);
    chk("tr_mready", 32'(m_ready), 32'h1);
    chk("tr_mrdata", m_rdata, 32'h0BAD_F00D);
    chk("tr_epulse", 32'(err_pulse), 32'h0);
    step(); m_valid = 1'b0; s_ready = '0; #1;
    chk("tr_after_busy", 32'(busy), 32'h0);
    chk("tr_after_epulse", 32'(err_pulse), 32'h0);
    chk("tr_after_ecount", 32'(err_count), 32'h2);

    // Abort: master drops m_valid mid-ACCESS.
    step(); request(32'h0000_0010, 32'h0, 4'h0); #1;
    step(); #1;
    chk("ab_svalid", 32'(s_valid), 32'h1);
    step(); m_valid = 1'b0; #1;
    step(); #1;
    chk("ab_svalid_off", 32'(s_valid), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_epulse", 32'(err_pulse), 32'h0);
    chk("ab_ecount", 32'(err_count), 32'h2);

    // Asynchronous reset mid-ACCESS.
    step(); request(32'h1000_0000, 32'h0, 4'h0); #1;
    step(); #1;
    chk("ar_pre_svalid", 32'(s_valid), 32'h4);
    #2 rst_n = 1'b0; #1;
    check_reset_values("ar");
    m_valid = 1'b0;
    step(); step(); rst_n = 1'b1;

    // 300 back-to-back misses saturate err_count at 255.
    step(); request(32'h3000_0000, 32'h0, 4'h0);
    pulses = 0;
    for (int k = 0; k < 600; k++) begin
      step(); #1;
      if (err_pulse) pulses++;
    end
    m_valid = 1'b0;
    chk("sat_pulses", 32'(pulses), 32'd300);
    chk("sat_ecount", 32'(err_count), 32'd255);
    step(); step(); #1;
    chk("sat_hold_ecount", 32'(err_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
